// File: rtl/eth_tlp_unpack.sv
// eth_tlp_unpack: strips Ethernet/IPv4/UDP headers from frames read out of a
// first-word-fall-through FIFO and emits the carried TLP as a 64-bit
// AXI-Stream with dword-granular keep. The 42-byte header ends two bytes into
// beat 5, so payload is realigned through a 48-bit hold register.
// Optional frame counters are built when ETH_TLP_UNPACK_STATS_EN is defined.
module eth_tlp_unpack #(
    parameter logic [15:0] UDP_PORT = 16'h3776
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rd_en,
    input  logic [73:0] dout,
    input  logic        empty,
    output logic [63:0] m_axis_tdata,
    output logic [1:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    output logic        m_axis_tuser,
    input  logic        m_axis_tready,
    output logic [31:0] stat_rx_frames,
    output logic [31:0] stat_drop_frames
);

    localparam logic [1:0] S_HDR   = 2'd0;
    localparam logic [1:0] S_PAY   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DROP  = 2'd3;

    logic [1:0]       state;
    logic [2:0]       beat_cnt;
    logic [47:0]      hold;
    logic             first;    // next PAY pop is beat 5 (fills hold only)
    logic             err;      // OR of tuser over the frame so far
    logic             flush_k;
    logic             flush_u;

    logic [7:0]       in_keep;
    logic [7:0][7:0]  in_b;
    logic             in_last;
    logic             in_user;
    logic             pop;
    logic             out_free;
    logic             hdr_ok;

    assign in_keep  = dout[73:66];
    assign in_b     = dout[65:2];
    assign in_last  = dout[1];
    assign in_user  = dout[0];
    assign pop      = rd_en && !empty;
    assign out_free = !m_axis_tvalid || m_axis_tready;

    // only the keep bits marking the dword boundaries matter
    logic unused_keep;
    assign unused_keep = &{1'b0, in_keep[7], in_keep[5:3]};

    // header field checks for the beat currently at the FIFO head
    always_comb begin
        hdr_ok = 1'b1;
        case (beat_cnt)
            3'd1:    hdr_ok = (in_b[4] == 8'h08) && (in_b[5] == 8'h00) && (in_b[6] == 8'h45);
            3'd2:    hdr_ok = (in_b[7] == 8'h11);
            3'd4:    hdr_ok = (in_b[4] == UDP_PORT[15:8]) && (in_b[5] == UDP_PORT[7:0]);
            default: hdr_ok = 1'b1;
        endcase
    end

    // pop request: header/drop beats always, payload only when output can take it
    always_comb begin
        rd_en = 1'b0;
        if (!rst && !empty) begin
            case (state)
                S_HDR, S_DROP: rd_en = 1'b1;
                S_PAY:         rd_en = first || out_free;
                default:       rd_en = 1'b0;
            endcase
        end
    end

    // frame state machine, realignment and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_HDR;
            beat_cnt      <= 3'd0;
            hold          <= 48'd0;
            first         <= 1'b0;
            err           <= 1'b0;
            flush_k       <= 1'b0;
            flush_u       <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= 64'd0;
            m_axis_tkeep  <= 2'b00;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready)
                m_axis_tvalid <= 1'b0;
            if (pop) begin
                if (in_last) begin
                    beat_cnt <= 3'd0;
                    err      <= 1'b0;
                end else begin
                    if (beat_cnt != 3'd5)
                        beat_cnt <= beat_cnt + 3'd1;
                    err <= err | in_user;
                end
            end
            case (state)
                S_HDR: begin
                    // a tlast here always ends a too-short frame; stay in HDR
                    if (pop && !in_last) begin
                        if (!hdr_ok)
                            state <= S_DROP;
                        else if (beat_cnt == 3'd4) begin
                            state <= S_PAY;
                            first <= 1'b1;
                        end
                    end
                end
                S_PAY: begin
                    if (pop) begin
                        hold <= dout[65:18];
                        if (first) begin
                            first <= 1'b0;
                            if (in_last)
                                state <= S_HDR;
                        end else begin
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= {dout[17:2], hold};
                            m_axis_tkeep  <= {in_keep[1], 1'b1};
                            m_axis_tlast  <= 1'b0;
                            m_axis_tuser  <= 1'b0;
                            if (in_last && in_keep[2]) begin
                                state   <= S_FLUSH;
                                flush_k <= in_keep[6];
                                flush_u <= err | in_user;
                            end else if (in_last) begin
                                m_axis_tlast <= 1'b1;
                                m_axis_tuser <= err | in_user;
                                state        <= S_HDR;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    if (out_free) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= {16'd0, hold};
                        m_axis_tkeep  <= {flush_k, 1'b1};
                        m_axis_tlast  <= 1'b1;
                        m_axis_tuser  <= flush_u;
                        state         <= S_HDR;
                    end
                end
                default: begin
                    if (pop && in_last)
                        state <= S_HDR;
                end
            endcase
        end
    end

`ifdef ETH_TLP_UNPACK_STATS_EN
    logic drop_evt;
    assign drop_evt = pop && in_last &&
                      ((state == S_HDR) || (state == S_DROP) || ((state == S_PAY) && first));

    // saturating frame counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_rx_frames   <= 32'd0;
            stat_drop_frames <= 32'd0;
        end else begin
            if (pop && in_last && (stat_rx_frames != 32'hFFFF_FFFF))
                stat_rx_frames <= stat_rx_frames + 32'd1;
            if (drop_evt && (stat_drop_frames != 32'hFFFF_FFFF))
                stat_drop_frames <= stat_drop_frames + 32'd1;
        end
    end
`else
    assign stat_rx_frames   = 32'd0;
    assign stat_drop_frames = 32'd0;
`endif

endmodule

// File: tb/tb_eth_tlp_unpack.sv
// Scoreboard bench for eth_tlp_unpack: frames are built as byte arrays, the
// expected TLP beats are derived from the payload bytes and queued, and a
// monitor compares every accepted output beat against the queue head.
module tb_eth_tlp_unpack;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [73:0] dout;
    logic        empty;
    logic [63:0] m_axis_tdata;
    logic [1:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tuser;
    logic        m_axis_tready;
    logic [31:0] stat_rx_frames;
    logic [31:0] stat_drop_frames;

    eth_tlp_unpack #(.UDP_PORT(16'h3776)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .dout(dout), .empty(empty),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
        .stat_rx_frames(stat_rx_frames), .stat_drop_frames(stat_drop_frames)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  k;
        logic        l;
        logic        u;
    } exp_t;

    exp_t        exp_q[$];
    logic [73:0] fifo_q[$];
    int          vectors = 0;
    int          errors  = 0;
    int          pop_cnt = 0;
    int          m_rx    = 0;
    int          m_drop  = 0;
    int          tready_mode = 0;
    bit          pop_req;

    // FWFT FIFO model: head presented at negedge, popped at the next posedge
    initial begin
        dout = '0;
        empty = 1'b1;
        pop_req = 1'b0;
        forever begin
            @(negedge clk);
            if (fifo_q.size() != 0) begin
                dout  = fifo_q[0];
                empty = 1'b0;
            end else begin
                dout  = '0;
                empty = 1'b1;
            end
            #1;
            pop_req = rd_en && !empty;
            @(posedge clk);
            if (pop_req && fifo_q.size() != 0) begin
                void'(fifo_q.pop_front());
                pop_cnt++;
            end
        end
    end

    // downstream ready: 0 always, 1 toggling, 2 random
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (tready_mode)
                1:       m_axis_tready = ~m_axis_tready;
                2:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b1;
            endcase
        end
    end

    // monitor: a beat is accepted at the posedge following valid&&ready here
    initial begin
        exp_t e;
        logic [63:0] mask;
        forever begin
            @(negedge clk);
            if (!rst && m_axis_tvalid && m_axis_tready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: got d=%h k=%b l=%b, expected no beat",
                             m_axis_tdata, m_axis_tkeep, m_axis_tlast);
                end else begin
                    e = exp_q.pop_front();
                    mask = e.k[1] ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
                    if ((((m_axis_tdata ^ e.d) & mask) != 64'd0) || m_axis_tkeep !== e.k ||
                        m_axis_tlast !== e.l || m_axis_tuser !== e.u) begin
                        errors++;
                        $display("FAIL out_beat: got d=%h k=%b l=%b u=%b, expected d=%h k=%b l=%b u=%b",
                                 m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
                                 e.d, e.k, e.l, e.u);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic chk_stats(input string tag);
`ifdef ETH_TLP_UNPACK_STATS_EN
        chk({tag, "_rx"},   64'(stat_rx_frames),   64'(m_rx));
        chk({tag, "_drop"}, 64'(stat_drop_frames), 64'(m_drop));
`else
        chk({tag, "_rx"},   64'(stat_rx_frames),   64'd0);
        chk({tag, "_drop"}, 64'(stat_drop_frames), 64'd0);
`endif
    endtask

    // bad: 0 ok, 1 EtherType 86DD, 2 IP version/IHL, 3 protocol, 4 UDP port
    task automatic send_frame(input int len, input int bad, input int err_beat);
        int n, nb, idx, rem;
        logic [7:0]  fb[];
        logic [73:0] w;
        bit ok, ferr;
        exp_t e;
        n  = 42 + len;
        nb = (n + 7) / 8;
        fb = new[n];
        foreach (fb[i]) fb[i] = 8'($urandom);
        fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45; fb[23] = 8'h11;
        fb[36] = 8'h37; fb[37] = 8'h76;
        case (bad)
            1: begin fb[12] = 8'h86; fb[13] = 8'hDD; end
            2: fb[14] = 8'h46;
            3: fb[23] = 8'h06;
            4: fb[37] = 8'h77;
            default: ;
        endcase
        for (int i = 0; i < nb; i++) begin
            w = '0;
            for (int j = 0; j < 8; j++) begin
                idx = 8 * i + j;
                if (idx < n) begin
                    w[2 + 8 * j +: 8] = fb[idx];
                    w[66 + j] = 1'b1;
                end else begin
                    w[2 + 8 * j +: 8] = 8'($urandom);
                end
            end
            w[1] = (i == nb - 1);
            w[0] = (i == err_beat);
            fifo_q.push_back(w);
        end
        ok   = (bad == 0) && (nb >= 7);
        ferr = (err_beat >= 0) && (err_beat < nb);
        m_rx++;
        if (!ok) m_drop++;
        else begin
            for (int c = 0; 8 * c < len; c++) begin
                e.d = '0;
                for (int j = 0; j < 8; j++)
                    if (8 * c + j < len) e.d[8 * j +: 8] = fb[42 + 8 * c + j];
                rem = len - 8 * c;
                e.k = {rem > 4, 1'b1};
                e.l = (8 * c + 8 >= len);
                e.u = e.l && ferr;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || m_axis_tvalid) && t < budget) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (t >= budget) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int base, t, len, bad, eb;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_rd_en",  64'(rd_en), 64'd0);
        chk("rst_tdata",  m_axis_tdata, 64'd0);
        chk("rst_tkeep",  64'(m_axis_tkeep), 64'd0);
        chk("rst_stat_rx", 64'(stat_rx_frames), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        send_frame(12, 0, -1);            // FLUSH path: keep 11 then 01
        drain(500);
        chk_stats("f12");
        send_frame(16, 0, -1);            // ends on keep 03, no FLUSH
        drain(500);
        send_frame(12, 1, -1);            // IPv6 EtherType, dropped
        send_frame(20, 0, -1);            // back-to-back valid frame
        drain(500);
        chk_stats("b2b");
        tready_mode = 1;
        send_frame(40, 0, -1);
        drain(1000);
        tready_mode = 0;
        send_frame(24, 0, 6);             // error flag on beat 6
        send_frame(4, 0, -1);             // too short, tlast on beat 5
        send_frame(28, 3, 2);             // bad protocol
        drain(500);
        chk_stats("dir");

        // reset while beat 7 of a 32-byte TLP is at the FIFO head
        base = pop_cnt;
        send_frame(32, 0, -1);
        t = 0;
        while (pop_cnt < base + 7 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("rst_wait_timeout", 64'(t >= 200), 64'd0);
        rst = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        m_rx = 0;
        m_drop = 0;
        #1;
        chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("midrst_rd_en", 64'(rd_en), 64'd0);
        chk("midrst_stat_rx", 64'(stat_rx_frames), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_frame(36, 0, -1);
        drain(500);
        chk_stats("postrst");

        // randomized traffic with random backpressure
        tready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            len = 4 * $urandom_range(1, 16);
            bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            eb  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 10)) : -1;
            send_frame(len, bad, eb);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain(20000);
        tready_mode = 0;
        chk_stats("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
